// File: rtl/target_reset_pattern_gen_pkg.sv
// Shared types and constants for the I3C Target Reset Pattern generator.
package target_reset_pattern_gen_pkg;

    localparam int TrPatternToggles = 14;

    typedef enum logic [2:0] {
        TR_IDLE,
        TR_SETUP,
        TR_TOGGLE,
        TR_SCL_HIGH,
        TR_SR,
        TR_STOP,
        TR_DONE
    } target_reset_gen_state_e;

endpackage

// File: rtl/target_reset_pattern_gen_phase_timer.sv
// Loadable down-counter for timed bus phases.
// A load of T gives a phase of T+1 cycles; expired_o marks the phase's last cycle.
module phase_timer #(
    parameter int CntW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    output logic            expired_o
);

    logic [CntW-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/target_reset_pattern_gen.sv
// Drives the I3C Target Reset Pattern: 14 SDA toggles with SCL low, then Sr, then P.
// While busy this block owns the SCL/SDA drive values.
//
// state       | meaning
// ------------+---------------------------------------------------------
// TR_IDLE     | lines released, waiting for req & enable & bus idle
// TR_SETUP    | SCL pulled low, SDA released, one t_low phase
// TR_TOGGLE   | SCL low, SDA toggles once per t_low phase (k = 1..14)
// TR_SCL_HIGH | SCL released with SDA high, one t_high phase
// TR_SR       | SDA pulled low while SCL high (repeated START)
// TR_STOP     | SDA released while SCL high (STOP)
// TR_DONE     | one-cycle completion pulse
module target_reset_pattern_gen
    import target_reset_pattern_gen_pkg::*;
#(
    parameter int CntW       = 16,
    parameter int NumToggles = TrPatternToggles
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enable_i,
    input  logic            req_i,
    input  logic            bus_idle_i,
    input  logic [CntW-1:0] t_low_i,
    input  logic [CntW-1:0] t_high_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            abort_o,
    output logic            scl_o,
    output logic            sda_o
);

    localparam logic [3:0] KLast = 4'(NumToggles);

    target_reset_gen_state_e state_q, state_d;
    logic [3:0]      k_q, k_d;
    logic [CntW-1:0] t_low_q, t_high_q;
    logic            abort_q, abort_d;
    logic            accept;
    logic            tmr_load;
    logic [CntW-1:0] tmr_val;
    logic            tmr_expired;

    phase_timer #(.CntW(CntW)) u_phase_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    assign accept = (state_q == TR_IDLE) && req_i && enable_i && bus_idle_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= TR_IDLE;
            k_q      <= '0;
            abort_q  <= 1'b0;
            t_low_q  <= '0;
            t_high_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            abort_q <= abort_d;
            if (accept) begin
                t_low_q  <= t_low_i;
                t_high_q <= t_high_i;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        abort_d  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = t_low_q;
        case (state_q)
            TR_IDLE: begin
                if (accept) begin
                    state_d  = TR_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = t_low_i;
                end
            end
            TR_SETUP: begin
                if (tmr_expired) begin
                    state_d  = TR_TOGGLE;
                    k_d      = 4'd1;
                    tmr_load = 1'b1;
                end
            end
            TR_TOGGLE: begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    if (k_q == KLast) begin
                        state_d = TR_SCL_HIGH;
                        tmr_val = t_high_q;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
            end
            TR_SCL_HIGH: begin
                if (tmr_expired) begin
                    state_d  = TR_SR;
                    tmr_load = 1'b1;
                    tmr_val  = t_high_q;
                end
            end
            TR_SR: begin
                if (tmr_expired) begin
                    state_d  = TR_STOP;
                    tmr_load = 1'b1;
                    tmr_val  = t_high_q;
                end
            end
            TR_STOP: begin
                if (tmr_expired) begin
                    state_d = TR_DONE;
                end
            end
            TR_DONE: begin
                state_d = TR_IDLE;
                k_d     = '0;
            end
            default: begin
                state_d = TR_IDLE;
                k_d     = '0;
            end
        endcase

        // Done always completes; any other active state is abandoned when disabled.
        if (!enable_i && state_q != TR_IDLE && state_q != TR_DONE) begin
            state_d  = TR_IDLE;
            k_d      = '0;
            abort_d  = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = '0;
        end
    end

    always_comb begin
        scl_o = 1'b1;
        sda_o = 1'b1;
        case (state_q)
            TR_SETUP:  scl_o = 1'b0;
            TR_TOGGLE: begin
                scl_o = 1'b0;
                sda_o = ~k_q[0];
            end
            TR_SR:     sda_o = 1'b0;
            default: ;
        endcase
    end

    assign busy_o  = (state_q != TR_IDLE);
    assign done_o  = (state_q == TR_DONE);
    assign abort_o = abort_q;

endmodule

// File: tb/tb_target_reset_pattern_gen.sv
// Directed self-checking bench for target_reset_pattern_gen.
module tb_target_reset_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        req;
    logic        bus_idle;
    logic [15:0] t_low;
    logic [15:0] t_high;
    logic        busy;
    logic        done;
    logic        abort;
    logic        scl;
    logic        sda;

    int n_tests = 0;
    int n_fail  = 0;

    target_reset_pattern_gen dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .enable_i   (enable),
        .req_i      (req),
        .bus_idle_i (bus_idle),
        .t_low_i    (t_low),
        .t_high_i   (t_high),
        .busy_o     (busy),
        .done_o     (done),
        .abort_o    (abort),
        .scl_o      (scl),
        .sda_o      (sda)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {scl, sda} for busy cycle c of a pattern (c = 0 is the first Setup cycle).
    function automatic logic [1:0] exp_lines(input int c, input int tl, input int th);
        int low_len;
        int p;
        int q;
        low_len = 15 * (tl + 1);
        if (c < low_len) begin
            p = c / (tl + 1);
            if (p == 0) return 2'b01;
            return (p % 2 == 1) ? 2'b00 : 2'b01;
        end
        q = (c - low_len) / (th + 1);
        if (q == 1) return 2'b10;
        return 2'b11;
    endfunction

    task automatic run_pattern(input int tl, input int th, input bit hold_req,
                               input bit mid_change, input bit drop_en_done);
        int total;
        int waits;
        int errs;
        int busy_n;
        int done_n;
        int simul;
        int edges;
        logic ps;
        logic pd;
        total  = 15 * (tl + 1) + 3 * (th + 1) + 1;
        waits  = 0;
        errs   = 0;
        busy_n = 0;
        done_n = 0;
        simul  = 0;
        edges  = 0;
        t_low  = 16'(tl);
        t_high = 16'(th);
        req    = 1'b1;
        while (waits < 10) begin
            step();
            waits++;
            if (busy) break;
        end
        chk("accept_latency", waits, 1);
        if (!hold_req) req = 1'b0;
        ps = 1'b1;
        pd = 1'b1;
        for (int c = 0; c < total; c++) begin
            if ({scl, sda} !== exp_lines(c, tl, th)) errs++;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (c != total - 1) errs++;
            end
            if (scl !== ps && sda !== pd) simul++;
            if (scl == 1'b0 && ps == 1'b0 && sda !== pd) edges++;
            ps = scl;
            pd = sda;
            if (mid_change && c == 20) t_low = 16'd10;
            if (drop_en_done && c == total - 1) enable = 1'b0;
            step();
        end
        chk("wave_errors", errs, 0);
        chk("busy_cycles", busy_n, total);
        chk("done_pulses", done_n, 1);
        chk("simul_changes", simul, 0);
        chk("sda_edges_scl_low", edges, 14);
        chk("idle_after", busy, 0);
        chk("abort_after", abort, 0);
        enable = 1'b1;
        t_low  = 16'(tl);
    endtask

    initial begin
        int cnt;
        rst      = 1'b1;
        enable   = 1'b1;
        req      = 1'b0;
        bus_idle = 1'b1;
        t_low    = '0;
        t_high   = '0;
        #2;
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_abort", abort, 0);
        step();
        step();
        rst = 1'b0;
        step();

        // Nominal: 15*4 + 3*5 + 1 = 76 busy cycles.
        run_pattern(3, 4, 1'b0, 1'b0, 1'b0);

        // Zero timing, enable dropped during Done must still complete cleanly.
        run_pattern(0, 0, 1'b0, 1'b0, 1'b1);

        // Gating on bus_idle.
        bus_idle = 1'b0;
        req      = 1'b1;
        cnt      = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy || !scl || !sda) cnt++;
        end
        chk("gate_no_start", cnt, 0);
        bus_idle = 1'b1;
        run_pattern(1, 2, 1'b0, 1'b0, 1'b0);

        // Abort during toggle k=7 (cycles 28..31 with t_low=3).
        t_low  = 16'd3;
        t_high = 16'd4;
        req    = 1'b1;
        step();
        chk("abort_accept", busy, 1);
        req = 1'b0;
        for (int i = 0; i < 29; i++) step();
        chk("k7_scl", scl, 0);
        chk("k7_sda", sda, 0);
        enable = 1'b0;
        step();
        chk("abort_pulse", abort, 1);
        chk("abort_scl", scl, 1);
        chk("abort_sda", sda, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        step();
        chk("abort_single", abort, 0);
        enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (done || busy) cnt++;
            step();
        end
        chk("abort_quiet", cnt, 0);

        // Async reset during Sr (t=2: Sr occupies cycles 48..50).
        t_low  = 16'd2;
        t_high = 16'd2;
        req    = 1'b1;
        step();
        chk("rst_mid_accept", busy, 1);
        req = 1'b0;
        for (int i = 0; i < 49; i++) step();
        chk("sr_scl", scl, 1);
        chk("sr_sda", sda, 0);
        rst = 1'b1;
        #1;
        chk("async_sda", sda, 1);
        chk("async_busy", busy, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_idle", busy, 0);
        run_pattern(2, 2, 1'b0, 1'b0, 1'b0);

        // Mid-pattern t_low change ignored; req held gives one Idle cycle then a restart.
        run_pattern(3, 4, 1'b1, 1'b1, 1'b0);
        step();
        chk("b2b_start", busy, 1);
        req = 1'b0;
        cnt = 0;
        while (busy && cnt < 300) begin
            step();
            cnt++;
        end
        chk("b2b_finish", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
